// File: rtl/mem_stage_pipe_if.sv
// Execute-side op bundle, RAM req/ack bus, MMR write port and writeback bundle of the memory stage.
interface mem_stage_pipe_if #(
  parameter int unsigned XLEN = 32
);
  // execute -> memory stage
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      mem_op;
  logic            mem_unsigned;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_we;
  logic            mmr_we_in;
  // RAM port
  logic            ram_req;
  logic            ram_we;
  logic [XLEN-1:0] ram_addr;
  logic [XLEN-1:0] ram_wdata;
  logic [3:0]      ram_be;
  logic [XLEN-1:0] ram_rdata;
  logic            ram_ack;
  // MMR write port
  logic            mmr_we;
  logic [XLEN-1:0] mmr_addr;
  logic [XLEN-1:0] mmr_wdata;
  // writeback and error strobes
  logic            wb_valid;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_rd_data;
  logic            wb_rd_we;
  logic            err_misalign;
  logic            err_bus;

  // memory stage view
  modport slave (
    input  in_valid, mem_op, mem_unsigned, addr, store_data, rd_addr, rd_data, rd_we,
           mmr_we_in, ram_rdata, ram_ack,
    output in_ready, ram_req, ram_we, ram_addr, ram_wdata, ram_be, mmr_we, mmr_addr,
           mmr_wdata, wb_valid, wb_rd_addr, wb_rd_data, wb_rd_we, err_misalign, err_bus
  );

  // surrounding pipeline / memory view
  modport master (
    output in_valid, mem_op, mem_unsigned, addr, store_data, rd_addr, rd_data, rd_we,
           mmr_we_in, ram_rdata, ram_ack,
    input  in_ready, ram_req, ram_we, ram_addr, ram_wdata, ram_be, mmr_we, mmr_addr,
           mmr_wdata, wb_valid, wb_rd_addr, wb_rd_data, wb_rd_we, err_misalign, err_bus
  );
endinterface

// File: rtl/mem_stage_pipe.sv
// Registered memory stage: RAM loads/stores over req/ack with timeout, MMR/NoC writes, writeback.
module mem_stage_pipe #(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] RAM_TOP       = XLEN'(32'h0000_3FFF),
  parameter logic [XLEN-1:0] MMR_BASE      = XLEN'(32'h0000_4000),
  parameter logic [XLEN-1:0] MMR_TOP       = XLEN'(32'h0000_400F),
  parameter logic [XLEN-1:0] NOC_FLAG_ADDR = XLEN'(32'h0000_4010),
  parameter int unsigned     TIMEOUT       = 16
) (
  input logic             clk,
  input logic             reset,
  mem_stage_pipe_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] NOC_END  = NOC_FLAG_ADDR + XLEN'(3);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_NOC  = 3'b011;
  localparam logic [2:0] OP_SB   = 3'b100;
  localparam logic [2:0] OP_LH   = 3'b101;
  localparam logic [2:0] OP_SH   = 3'b110;

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            ram_req_q, ram_req_d;
  logic            ram_we_q, ram_we_d;
  logic [XLEN-1:0] ram_addr_q, ram_addr_d;
  logic [XLEN-1:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]      ram_be_q, ram_be_d;
  logic            mmr_we_q, mmr_we_d;
  logic [XLEN-1:0] mmr_addr_q, mmr_addr_d;
  logic [XLEN-1:0] mmr_wdata_q, mmr_wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;
  logic [XLEN-1:0] wb_rd_data_q, wb_rd_data_d;
  logic            wb_rd_we_q, wb_rd_we_d;
  logic            err_misalign_q, err_misalign_d;
  logic            err_bus_q, err_bus_d;
  // op context kept for the duration of a RAM access
  logic [2:0]      lat_op_q, lat_op_d;
  logic [1:0]      lat_lo_q, lat_lo_d;
  logic            lat_uns_q, lat_uns_d;
  logic            lat_rd_we_q, lat_rd_we_d;

  logic            op_store, misaligned, in_ram, in_mmr, in_noc;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  // Decode of the op presented by execute.
  assign op_store   = (bus.mem_op == OP_SW) || (bus.mem_op == OP_SB) || (bus.mem_op == OP_SH);
  assign misaligned = (((bus.mem_op == OP_LW) || (bus.mem_op == OP_SW)) && (bus.addr[1:0] != 2'b00))
                   || (((bus.mem_op == OP_LH) || (bus.mem_op == OP_SH)) && bus.addr[0]);
  assign in_ram     = (bus.addr <= RAM_TOP);
  assign in_mmr     = (bus.addr >= MMR_BASE) && (bus.addr <= MMR_TOP);
  assign in_noc     = (bus.addr >= NOC_FLAG_ADDR) && (bus.addr <= NOC_END);

  // Byte enables and lane-replicated write data for the store width.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = bus.store_data;
    if (bus.mem_op == OP_SB) begin
      be_c    = 4'b0001 << bus.addr[1:0];
      wdata_c = {(XLEN/8){bus.store_data[7:0]}};
    end else if (bus.mem_op == OP_SH) begin
      be_c    = 4'b0011 << bus.addr[1:0];
      wdata_c = {(XLEN/16){bus.store_data[15:0]}};
    end
  end

  // Lane select and sign/zero extension of returned read data.
  always_comb begin
    case (lat_lo_q)
      2'd0:    ld_byte = bus.ram_rdata[7:0];
      2'd1:    ld_byte = bus.ram_rdata[15:8];
      2'd2:    ld_byte = bus.ram_rdata[23:16];
      default: ld_byte = bus.ram_rdata[31:24];
    endcase
    ld_half = lat_lo_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    if (lat_op_q == OP_LW) begin
      load_data = bus.ram_rdata;
    end else if (lat_op_q == OP_LH) begin
      load_data = {{(XLEN-16){ld_half[15] & ~lat_uns_q}}, ld_half};
    end else begin
      load_data = {{(XLEN-8){ld_byte[7] & ~lat_uns_q}}, ld_byte};
    end
  end

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ram_req_d      = ram_req_q;
    ram_we_d       = ram_we_q;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    ram_be_d       = ram_be_q;
    mmr_we_d       = 1'b0;
    mmr_addr_d     = mmr_addr_q;
    mmr_wdata_d    = mmr_wdata_q;
    wb_valid_d     = 1'b0;
    wb_rd_addr_d   = wb_rd_addr_q;
    wb_rd_data_d   = wb_rd_data_q;
    wb_rd_we_d     = wb_rd_we_q;
    err_misalign_d = 1'b0;
    err_bus_d      = 1'b0;
    lat_op_d       = lat_op_q;
    lat_lo_d       = lat_lo_q;
    lat_uns_d      = lat_uns_q;
    lat_rd_we_d    = lat_rd_we_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          wb_rd_addr_d = bus.rd_addr;
          wb_rd_data_d = '0;
          wb_rd_we_d   = 1'b0;
          if (bus.mem_op == OP_NONE) begin
            wb_valid_d   = 1'b1;
            wb_rd_data_d = bus.rd_data;
            wb_rd_we_d   = bus.rd_we;
          end else if (bus.mem_op == OP_NOC) begin
            wb_valid_d = 1'b1;
            if (in_mmr) begin
              mmr_we_d    = bus.mmr_we_in;
              mmr_addr_d  = bus.addr;
              mmr_wdata_d = bus.store_data;
            end else if (in_noc) begin
              mmr_we_d    = bus.mmr_we_in;
              mmr_addr_d  = NOC_FLAG_ADDR;
              mmr_wdata_d = XLEN'(1);
            end else begin
              err_bus_d = 1'b1;
            end
          end else if (misaligned) begin
            wb_valid_d     = 1'b1;
            err_misalign_d = 1'b1;
          end else if (!in_ram) begin
            wb_valid_d = 1'b1;
            err_bus_d  = 1'b1;
          end else begin
            ram_req_d   = 1'b1;
            ram_we_d    = op_store;
            ram_addr_d  = {bus.addr[XLEN-1:2], 2'b00};
            ram_be_d    = be_c;
            ram_wdata_d = wdata_c;
            lat_op_d    = bus.mem_op;
            lat_lo_d    = bus.addr[1:0];
            lat_uns_d   = bus.mem_unsigned;
            lat_rd_we_d = bus.rd_we;
            cnt_d       = '0;
            state_d     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.ram_ack) begin
          ram_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          state_d    = ST_IDLE;
          if (ram_we_q) begin
            wb_rd_data_d = '0;
            wb_rd_we_d   = 1'b0;
          end else begin
            wb_rd_data_d = load_data;
            wb_rd_we_d   = lat_rd_we_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          ram_req_d    = 1'b0;
          err_bus_d    = 1'b1;
          wb_valid_d   = 1'b1;
          wb_rd_data_d = '0;
          wb_rd_we_d   = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      in_ready_q     <= 1'b1;
      ram_req_q      <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      ram_be_q       <= '0;
      mmr_we_q       <= 1'b0;
      mmr_addr_q     <= '0;
      mmr_wdata_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_addr_q   <= '0;
      wb_rd_data_q   <= '0;
      wb_rd_we_q     <= 1'b0;
      err_misalign_q <= 1'b0;
      err_bus_q      <= 1'b0;
      lat_op_q       <= '0;
      lat_lo_q       <= '0;
      lat_uns_q      <= 1'b0;
      lat_rd_we_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      in_ready_q     <= in_ready_d;
      ram_req_q      <= ram_req_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      ram_be_q       <= ram_be_d;
      mmr_we_q       <= mmr_we_d;
      mmr_addr_q     <= mmr_addr_d;
      mmr_wdata_q    <= mmr_wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_addr_q   <= wb_rd_addr_d;
      wb_rd_data_q   <= wb_rd_data_d;
      wb_rd_we_q     <= wb_rd_we_d;
      err_misalign_q <= err_misalign_d;
      err_bus_q      <= err_bus_d;
      lat_op_q       <= lat_op_d;
      lat_lo_q       <= lat_lo_d;
      lat_uns_q      <= lat_uns_d;
      lat_rd_we_q    <= lat_rd_we_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.ram_req      = ram_req_q;
  assign bus.ram_we       = ram_we_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.ram_be       = ram_be_q;
  assign bus.mmr_we       = mmr_we_q;
  assign bus.mmr_addr     = mmr_addr_q;
  assign bus.mmr_wdata    = mmr_wdata_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd_addr   = wb_rd_addr_q;
  assign bus.wb_rd_data   = wb_rd_data_q;
  assign bus.wb_rd_we     = wb_rd_we_q;
  assign bus.err_misalign = err_misalign_q;
  assign bus.err_bus      = err_bus_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: hand-computed expectations checked one cycle at a time.
module tb_mem_stage_pipe;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cnt;

  mem_stage_pipe_if #(.XLEN(32)) bus ();

  mem_stage_pipe #(
    .XLEN          (32),
    .RAM_TOP       (32'h0000_3FFF),
    .MMR_BASE      (32'h0000_4000),
    .MMR_TOP       (32'h0000_400F),
    .NOC_FLAG_ADDR (32'h0000_4010),
    .TIMEOUT       (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic uns);
    bus.in_valid     = 1'b1;
    bus.mem_op       = op;
    bus.addr         = a;
    bus.store_data   = sd;
    bus.mem_unsigned = uns;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.in_valid = 1'b0; bus.mem_op = 3'b000; bus.mem_unsigned = 1'b0;
    bus.addr = '0; bus.store_data = '0; bus.rd_addr = '0; bus.rd_data = '0;
    bus.rd_we = 1'b0; bus.mmr_we_in = 1'b0; bus.ram_rdata = '0; bus.ram_ack = 1'b0;

    // reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ram_req",  32'(bus.ram_req),  32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_errs",     32'({bus.err_bus, bus.err_misalign, bus.mmr_we}), 32'd0);

    // op none, three back-to-back
    drive(3'b000, 32'h0, 32'h0, 1'b0);
    bus.rd_addr = 5'd5; bus.rd_data = 32'hDEAD_BEEF; bus.rd_we = 1'b1;
    tick();
    chk("none0_valid", 32'(bus.wb_valid),   32'd1);
    chk("none0_data",  bus.wb_rd_data,      32'hDEAD_BEEF);
    chk("none0_rd",    32'(bus.wb_rd_addr), 32'd5);
    chk("none0_we",    32'(bus.wb_rd_we),   32'd1);
    bus.rd_data = 32'h0000_0011;
    tick();
    chk("none1_valid", 32'(bus.wb_valid), 32'd1);
    chk("none1_data",  bus.wb_rd_data,    32'h0000_0011);
    bus.rd_data = 32'h0000_0022;
    tick();
    chk("none2_valid", 32'(bus.wb_valid), 32'd1);
    chk("none2_data",  bus.wb_rd_data,    32'h0000_0022);
    bus.in_valid = 1'b0;
    tick();
    chk("none_idle_valid", 32'(bus.wb_valid), 32'd0);

    // LB signed at 0x103, ack after 3 wait cycles
    drive(3'b111, 32'h0000_0103, 32'h0, 1'b0);
    bus.rd_addr = 5'd7; bus.rd_we = 1'b1; bus.ram_rdata = 32'h80FF_0000;
    tick();
    bus.in_valid = 1'b0;
    chk("lb_req",   32'(bus.ram_req), 32'd1);
    chk("lb_addr",  bus.ram_addr,     32'h0000_0100);
    chk("lb_we",    32'(bus.ram_we),  32'd0);
    chk("lb_be",    32'(bus.ram_be),  32'hF);
    cnt = (bus.in_ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.in_ready == 1'b0) cnt++;
    end
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("lb_ready_low_cycles", 32'(cnt),     32'd4);
    chk("lb_wb_valid",   32'(bus.wb_valid),  32'd1);
    chk("lb_data",       bus.wb_rd_data,     32'hFFFF_FF80);
    chk("lb_wb_we",      32'(bus.wb_rd_we),  32'd1);
    chk("lb_req_drop",   32'(bus.ram_req),   32'd0);
    chk("lb_ready_back", 32'(bus.in_ready),  32'd1);

    // LBU, same access with immediate ack
    drive(3'b111, 32'h0000_0103, 32'h0, 1'b1);
    tick();
    bus.in_valid = 1'b0; bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("lbu_data", bus.wb_rd_data, 32'h0000_0080);

    // LH signed at 0x102 selects the upper half
    drive(3'b101, 32'h0000_0102, 32'h0, 1'b0);
    tick();
    bus.in_valid = 1'b0; bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("lh_data", bus.wb_rd_data, 32'hFFFF_80FF);

    // SH at 0x202, immediate ack
    drive(3'b110, 32'h0000_0202, 32'h1234_ABCD, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("sh_be",    32'(bus.ram_be), 32'hC);
    chk("sh_wdata", bus.ram_wdata,   32'hABCD_ABCD);
    chk("sh_we",    32'(bus.ram_we), 32'd1);
    chk("sh_addr",  bus.ram_addr,    32'h0000_0200);
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("sh_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("sh_wb_we",    32'(bus.wb_rd_we), 32'd0);
    chk("sh_wb_data",  bus.wb_rd_data,    32'h0);

    // SB at 0x301
    drive(3'b100, 32'h0000_0301, 32'hCAFE_005A, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("sb_be",    32'(bus.ram_be), 32'h2);
    chk("sb_wdata", bus.ram_wdata,   32'h5A5A_5A5A);
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;

    // misaligned LW
    drive(3'b001, 32'h0000_0002, 32'h0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("mis_err",   32'(bus.err_misalign), 32'd1);
    chk("mis_bus",   32'(bus.err_bus),      32'd0);
    chk("mis_req",   32'(bus.ram_req),      32'd0);
    chk("mis_wb",    32'({bus.wb_valid, bus.wb_rd_we}), 32'b10);
    tick();
    chk("mis_pulse", 32'(bus.err_misalign), 32'd0);

    // out-of-range LW
    drive(3'b001, 32'h0000_5000, 32'h0, 1'b0);
    tick();
    chk("rng_bus", 32'(bus.err_bus),      32'd1);
    chk("rng_mis", 32'(bus.err_misalign), 32'd0);
    chk("rng_req", 32'(bus.ram_req),      32'd0);

    // misaligned and out of range: misalignment reported
    drive(3'b001, 32'h0000_5002, 32'h0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("prio_mis", 32'(bus.err_misalign), 32'd1);
    chk("prio_bus", 32'(bus.err_bus),      32'd0);

    // timeout: ack never arrives
    drive(3'b001, 32'h0000_0010, 32'h0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    cnt = bus.ram_req ? 1 : 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.ram_req) cnt++;
    end
    chk("to_req_cycles", 32'(cnt), 32'd16);
    tick();
    chk("to_req",   32'(bus.ram_req),  32'd0);
    chk("to_err",   32'(bus.err_bus),  32'd1);
    chk("to_wb",    32'({bus.wb_valid, bus.wb_rd_we}), 32'b10);
    chk("to_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("to_pulse", 32'(bus.err_bus), 32'd0);

    // ack on the final wait cycle wins over timeout
    drive(3'b001, 32'h0000_0010, 32'h0, 1'b0);
    bus.ram_rdata = 32'h1357_9BDF;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("late_ack_err",  32'(bus.err_bus),  32'd0);
    chk("late_ack_wb",   32'(bus.wb_valid), 32'd1);
    chk("late_ack_data", bus.wb_rd_data,    32'h1357_9BDF);

    // NOC write into MMR data window
    drive(3'b011, 32'h0000_4004, 32'h0000_0007, 1'b0);
    bus.mmr_we_in = 1'b1;
    tick();
    chk("noc_we",    32'(bus.mmr_we), 32'd1);
    chk("noc_addr",  bus.mmr_addr,    32'h0000_4004);
    chk("noc_wdata", bus.mmr_wdata,   32'h0000_0007);
    chk("noc_wb",    32'({bus.wb_valid, bus.wb_rd_we}), 32'b10);
    chk("noc_req",   32'(bus.ram_req), 32'd0);

    // NOC flag window
    drive(3'b011, 32'h0000_4012, 32'h0000_0099, 1'b0);
    tick();
    chk("flag_we",    32'(bus.mmr_we), 32'd1);
    chk("flag_addr",  bus.mmr_addr,    32'h0000_4010);
    chk("flag_wdata", bus.mmr_wdata,   32'h0000_0001);

    // NOC outside both windows
    drive(3'b011, 32'h0000_5000, 32'h0, 1'b0);
    tick();
    bus.in_valid = 1'b0; bus.mmr_we_in = 1'b0;
    chk("nocbad_err", 32'(bus.err_bus), 32'd1);
    chk("nocbad_we",  32'(bus.mmr_we),  32'd0);

    // stray ack while idle
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("stray_ack_wb", 32'(bus.wb_valid), 32'd0);

    // reset during WAIT
    drive(3'b001, 32'h0000_0020, 32'h0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rw_req_before", 32'(bus.ram_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_req",   32'(bus.ram_req),  32'd0);
    chk("rw_wb",    32'(bus.wb_valid), 32'd0);
    chk("rw_ready", 32'(bus.in_ready), 32'd1);
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("rw_no_wb", 32'({bus.wb_valid, bus.err_bus}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Registered, parametrised successor to the combinational memory stage.
- Accepts one memory-stage op per handshake and performs:
  - word/half/byte loads and stores (signed and unsigned) to RAM through a req/ack handshake, with wait-state support;
  - memory-mapped register (MMR) writes, including the NoC "load" and "store" flags.
- Drives a registered writeback bundle and back-pressures the execute stage while a RAM access is outstanding.

Parameters:
- XLEN, 32, data/address width.
- RAM_TOP, 32'h0000_3FFF, last RAM byte address; RAM base is 0.
- MMR_BASE, 32'h0000_4000, first MMR data address.
- MMR_TOP, 32'h0000_400F, last MMR data address.
- NOC_FLAG_ADDR, 32'h0000_4010, store-NoC flag register; decodes NOC_FLAG_ADDR..NOC_FLAG_ADDR+3.
- TIMEOUT, 16, max cycles to wait for ram_ack before abort (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  execute stage presents an op.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- mem_op  in  3  000 none, 001 LW, 010 SW, 011 NOC write, 100 SB, 101 LH, 110 SH, 111 LB.
- mem_unsigned  in  1  zero-extend LB/LH (LBU/LHU).
- addr  in  XLEN  effective address from EX.
- store_data  in  XLEN  rs2 value.
- rd_addr  in  5  destination register.
- rd_data  in  XLEN  ALU result for op none.
- rd_we  in  1  register write enable.
- mmr_we_in  in  1  MMR write permission from decode.
- ram_req  out  1  RAM request, held until ack.
- ram_we  out  1  1 = write.
- ram_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00}).
- ram_wdata  out  XLEN  lane-replicated store data.
- ram_be  out  4  byte enables.
- ram_rdata  in  XLEN  read data, valid with ram_ack.
- ram_ack  in  1  completes the request.
- mmr_we  out  1  one-cycle MMR write strobe.
- mmr_addr  out  XLEN  MMR address.
- mmr_wdata  out  XLEN  MMR write data.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd_addr  out  5  writeback register.
- wb_rd_data  out  XLEN  writeback data.
- wb_rd_we  out  1  writeback enable.
- err_misalign  out  1  one-cycle pulse: misaligned LW/SW/LH/SH.
- err_bus  out  1  one-cycle pulse: address out of range or timeout.

Behaviour:
- Reset:
  - state IDLE, timeout counter 0.
  - All outputs 0 except in_ready=1.
  - Reset during WAIT drops ram_req at that edge; no writeback or error follows.
- Accept: op is taken at a rising edge with in_valid && in_ready. All registered outputs below update at that edge.
- Op none:
  - wb_valid=1, wb_rd_* = inputs.
  - Latency 1 cycle; state stays IDLE (back-to-back ops allowed).
- Alignment:
  - LW/SW require addr[1:0]==0; LH/SH require addr[0]==0.
  - On violation: err_misalign=1, wb_valid=1, wb_rd_we=0; no RAM or MMR access.
- Range:
  - RAM ops (LW/LB/LH/SW/SB/SH) require addr<=RAM_TOP.
  - Otherwise: err_bus=1, wb_valid=1, wb_rd_we=0.
  - Misalignment takes priority over range.
- RAM op:
  - On accept: ram_req=1, latch ram_addr/ram_we/ram_be/ram_wdata, enter WAIT.
  - Byte enables: SB -> 4'b0001<<addr[1:0]; SH -> 4'b0011<<addr[1:0]; SW/loads -> 4'b1111.
  - ram_wdata: store byte replicated x4, half replicated x2, word unchanged.
- WAIT:
  - Outputs held stable; in_ready=0.
  - On edge with ram_ack: ram_req=0, wb_valid=1, state IDLE.
  - Load: select byte/half by latched addr[1:0] and sign- or zero-extend per mem_unsigned. wb_rd_we = latched rd_we.
  - Store: wb_rd_we=0, wb_rd_data=0.
  - ack on the first WAIT cycle gives total latency 2 cycles.
- Timeout:
  - Counter increments each WAIT cycle without ack.
  - When it reaches TIMEOUT-1 and ack is still absent: ram_req=0, err_bus=1, wb_valid=1, wb_rd_we=0, state IDLE.
  - ack on that same cycle wins.
- NOC write (011), 1-cycle latency, no RAM access; wb_valid=1, wb_rd_we=0:
  - addr in [MMR_BASE,MMR_TOP]: mmr_we=mmr_we_in, mmr_addr=addr, mmr_wdata=store_data.
  - addr in NOC flag window: mmr_we=mmr_we_in, mmr_addr=NOC_FLAG_ADDR, mmr_wdata=1.
  - Otherwise: err_bus=1, mmr_we=0.
- Strobes (wb_valid, mmr_we, err_*) are single-cycle. They return to 0 on the next edge unless a new op is accepted there.
- ram_ack outside WAIT is ignored.

Test Plan:
- Op none, rd_addr=5, rd_data=0xDEAD_BEEF, rd_we=1 -> next cycle wb_valid=1, wb_rd_data=0xDEADBEEF; three back-to-back ops give three consecutive wb_valid pulses.
- LB addr=0x0000_0103, ram_rdata=0x80FF_0000, ack after 3 wait cycles -> in_ready low 4 cycles, ram_addr=0x100, wb_rd_data=0xFFFF_FF80. Same with mem_unsigned=1 -> 0x0000_0080.
- SH addr=0x0000_0202, store_data=0x1234_ABCD, immediate ack -> ram_be=4'b1100, ram_wdata=0xABCD_ABCD, ram_we=1, wb_rd_we=0.
- LW addr=0x0000_0002 -> err_misalign=1, no ram_req. LW addr=0x0000_5000 -> err_bus=1, no ram_req.
- ram_ack never asserted, TIMEOUT=16 -> ram_req high exactly 16 cycles, then err_bus pulse, wb_rd_we=0, in_ready=1.
- NOC write addr=0x4004, data=7, mmr_we_in=1 -> mmr_we pulse, mmr_addr=0x4004, mmr_wdata=7. addr=0x4012 -> mmr_addr=0x4010, mmr_wdata=1. Reset asserted mid-WAIT -> ram_req=0 next edge, no wb_valid.
